// File: rtl/car_traffic_controller_pkg.sv
// Shared constants, defaults and state encoding for the car traffic controller.
// Optional build macro CAR_SPAWN_JITTER_EN enables the wrap jitter LFSR.
package car_traffic_controller_pkg;

   localparam int NUM_CARS      = 8;
   localparam int X_W           = 10;
   localparam int LVL_W         = 3;
   localparam int S_W           = 5;
   localparam int H_DISPLAY_DEF = 640;
   localparam int CAR_WIDTH     = 32;
   localparam int MAX_LEVEL_DEF = 7;

   localparam logic [31:0] SPEED_TABLE_DEF = 32'h4321_4321;
   localparam logic [7:0]  DIR_MASK_DEF    = 8'b1010_1010;

   // Field N-1 (10 bits each, car 1 in the LSBs) is the reset X of car N.
   localparam logic [NUM_CARS*X_W-1:0] INIT_X_DEF = {
      10'd320, 10'd3, 10'd639, 10'd0, 10'd636, 10'd0, 10'd630, 10'd1
   };

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/car_traffic_controller_if.sv
// Control/status bundle between the frame timing logic and the car controller.
interface car_traffic_controller_if;
   logic       frame_tick;
   logic       pause;
   logic       level_up;
   logic       level_reset;
   logic [2:0] level;
   logic [9:0] car_x1, car_x2, car_x3, car_x4;
   logic [9:0] car_x5, car_x6, car_x7, car_x8;
   logic       update_done;
   logic       tick_overrun;

   modport master (
      output frame_tick, pause, level_up, level_reset,
      input  level, car_x1, car_x2, car_x3, car_x4,
             car_x5, car_x6, car_x7, car_x8, update_done, tick_overrun
   );

   modport slave (
      input  frame_tick, pause, level_up, level_reset,
      output level, car_x1, car_x2, car_x3, car_x4,
             car_x5, car_x6, car_x7, car_x8, update_done, tick_overrun
   );
endinterface

// File: rtl/car_traffic_controller_car_step_alu.sv
// Single-car position step: moves x by s in direction dir, wrapping modulo H_DISPLAY.
module car_step_alu #(
   parameter int H_DISPLAY = 640
) (
   input  logic [9:0] x,
   input  logic [4:0] s,
   input  logic       dir,
   output logic [9:0] x_next,
   output logic       wrap
);

   localparam logic [10:0] H11 = 11'(H_DISPLAY);
   localparam logic [9:0]  H10 = 10'(H_DISPLAY);

   logic [10:0] sum11;
   logic [9:0]  s10;

   // The 11-bit sum only decides the wrap; the result always fits in 10 bits.
   always_comb begin
      s10    = {5'b0, s};
      sum11  = {1'b0, x} + {6'b0, s};
      wrap   = 1'b0;
      x_next = x;
      if (dir) begin
         wrap   = (sum11 >= H11);
         x_next = wrap ? (x + s10 - H10) : (x + s10);
      end else begin
         wrap   = (x < s10);
         x_next = wrap ? (x + H10 - s10) : (x - s10);
      end
   end

endmodule

// File: rtl/car_traffic_controller.sv
// Per-frame car position updater with atomic commit of all eight positions.
// Build macro CAR_SPAWN_JITTER_EN adds LFSR jitter to wrapped positions.
module car_traffic_controller
   import car_traffic_controller_pkg::*;
#(
   parameter int                        H_DISPLAY    = H_DISPLAY_DEF,
   parameter logic [31:0]               SPEED_TABLE  = SPEED_TABLE_DEF,
   parameter logic [7:0]                DIR_MASK     = DIR_MASK_DEF,
   parameter logic [NUM_CARS*X_W-1:0]   INIT_X_TABLE = INIT_X_DEF,
   parameter int                        MAX_LEVEL    = MAX_LEVEL_DEF
) (
   input logic                      CLK,
   input logic                      RST,
   car_traffic_controller_if.slave  bus
);

   state_e             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [LVL_W-1:0]   lvl_lat_q, lvl_lat_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [X_W-1:0]     shadow_q [NUM_CARS];
   logic [X_W-1:0]     shadow_d [NUM_CARS];
   logic [X_W-1:0]     car_x_q  [NUM_CARS];
   logic [X_W-1:0]     car_x_d  [NUM_CARS];
   logic               update_done_q, update_done_d;
   logic               tick_overrun_q, tick_overrun_d;

   logic [X_W-1:0]     alu_x, alu_xn, step_x;
   logic [S_W-1:0]     alu_s;
   logic               alu_dir, alu_wrap;

   function automatic logic [LVL_W-1:0] sat_inc(input logic [LVL_W-1:0] v);
      return (v >= LVL_W'(MAX_LEVEL)) ? v : v + 1'b1;
   endfunction

   assign alu_x   = shadow_q[idx_q];
   assign alu_s   = {1'b0, SPEED_TABLE[{idx_q, 2'b00} +: 4]} + {2'b00, lvl_lat_q};
   assign alu_dir = DIR_MASK[idx_q];

   car_step_alu #(.H_DISPLAY(H_DISPLAY)) u_step (
      .x      (alu_x),
      .s      (alu_s),
      .dir    (alu_dir),
      .x_next (alu_xn),
      .wrap   (alu_wrap)
   );

`ifdef CAR_SPAWN_JITTER_EN
   localparam logic [10:0] H11 = 11'(H_DISPLAY);
   localparam logic [9:0]  H10 = 10'(H_DISPLAY);

   logic [15:0] lfsr_q, lfsr_d;
   logic [10:0] jit_sum;
   logic [9:0]  jit_x;

   // A wrapped car re-enters offset by up to 15 pixels, folded back into range.
   always_comb begin
      jit_sum = {1'b0, alu_xn} + {7'b0, lfsr_q[3:0]};
      jit_x   = alu_xn + {6'b0, lfsr_q[3:0]};
      if (jit_sum >= H11) jit_x = jit_x - H10;
      step_x  = alu_wrap ? jit_x : alu_xn;
   end
`else
   logic wrap_unused;
   assign wrap_unused = alu_wrap;
   assign step_x      = alu_xn;
`endif

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      lvl_lat_d      = lvl_lat_q;
      update_done_d  = 1'b0;
      tick_overrun_d = tick_overrun_q;
      for (int i = 0; i < NUM_CARS; i++) begin
         shadow_d[i] = shadow_q[i];
         car_x_d[i]  = car_x_q[i];
      end
`ifdef CAR_SPAWN_JITTER_EN
      lfsr_d = lfsr_q;
`endif

      if (bus.level_reset)   level_d = '0;
      else if (bus.level_up) level_d = sat_inc(level_q);
      else                   level_d = level_q;

      case (state_q)
         ST_IDLE: begin
            // pause only gates the start of an update; it never aborts one.
            if (bus.frame_tick && !bus.pause) begin
               state_d   = ST_UPDATE;
               idx_d     = '0;
               lvl_lat_d = level_q;
               for (int i = 0; i < NUM_CARS; i++) shadow_d[i] = car_x_q[i];
            end
         end
         ST_UPDATE: begin
            shadow_d[idx_q] = step_x;
            idx_d           = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = ST_COMMIT;
            if (bus.frame_tick) tick_overrun_d = 1'b1;
         end
         ST_COMMIT: begin
            for (int i = 0; i < NUM_CARS; i++) car_x_d[i] = shadow_q[i];
            update_done_d = 1'b1;
            state_d       = ST_IDLE;
`ifdef CAR_SPAWN_JITTER_EN
            lfsr_d = lfsr_next(lfsr_q);
`endif
            if (bus.frame_tick) tick_overrun_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         lvl_lat_q      <= '0;
         level_q        <= '0;
         update_done_q  <= 1'b0;
         tick_overrun_q <= 1'b0;
         for (int i = 0; i < NUM_CARS; i++) begin
            shadow_q[i] <= INIT_X_TABLE[i*X_W +: X_W];
            car_x_q[i]  <= INIT_X_TABLE[i*X_W +: X_W];
         end
`ifdef CAR_SPAWN_JITTER_EN
         lfsr_q <= LFSR_SEED;
`endif
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         lvl_lat_q      <= lvl_lat_d;
         level_q        <= level_d;
         update_done_q  <= update_done_d;
         tick_overrun_q <= tick_overrun_d;
         for (int i = 0; i < NUM_CARS; i++) begin
            shadow_q[i] <= shadow_d[i];
            car_x_q[i]  <= car_x_d[i];
         end
`ifdef CAR_SPAWN_JITTER_EN
         lfsr_q <= lfsr_d;
`endif
      end
   end

   assign bus.level        = level_q;
   assign bus.update_done  = update_done_q;
   assign bus.tick_overrun = tick_overrun_q;
   assign bus.car_x1       = car_x_q[0];
   assign bus.car_x2       = car_x_q[1];
   assign bus.car_x3       = car_x_q[2];
   assign bus.car_x4       = car_x_q[3];
   assign bus.car_x5       = car_x_q[4];
   assign bus.car_x6       = car_x_q[5];
   assign bus.car_x7       = car_x_q[6];
   assign bus.car_x8       = car_x_q[7];

endmodule
